sipo_rx_ctrl: RTL and testbench

// Receive-side controller that sequences a WIDTH-bit serial-in/parallel-out shifter for framed serial data.

---
 rtl/sipo_rx_ctrl_if.sv | 21 ++
 rtl/sipo_rx_ctrl.sv | 147 ++++++++++++++
 tb/tb_sipo_rx_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sipo_rx_ctrl_if.sv
// Parallel output handshake between sipo_rx_ctrl and its downstream consumer.
// Valid/ready: a word transfers on a rising clk edge where out_valid && out_ready; out_data is stable while out_valid=1.
interface sipo_rx_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/sipo_rx_ctrl.sv
// Framed serial receiver: start detect, LSB-first shift of WIDTH bits, stop check, one-entry output holding register.
// Optional parity check is built in when the PARITY_CHK_EN macro is defined.
module sipo_rx_ctrl #(
  parameter int WIDTH      = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_en,
  input  logic        sr_in,
  input  logic        clr_err,
  sipo_rx_ctrl_if.master out_if,
  output logic        busy,
  output logic        frame_err,
  output logic        parity_err,
  output logic        overrun,
  output logic [1:0]  dbg_state_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;
`ifdef PARITY_CHK_EN
  logic             par_bad_q, par_bad_d;
  logic             parity_err_q, parity_err_d;
`else
  logic             unused_cfg;
  assign unused_cfg = PARITY_ODD;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef PARITY_CHK_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
`ifdef PARITY_CHK_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
`ifdef PARITY_CHK_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    if (valid_q && out_if.out_ready) valid_d = 1'b0;
    // A new overrun assigned below overrides a simultaneous clear.
    if (clr_err) overrun_d = 1'b0;
    if (bit_en) begin
      case (state_q)
        ST_IDLE: begin
          if (!sr_in) begin
            state_d = ST_SHIFT;
            cnt_d   = '0;
          end
        end
        ST_SHIFT: begin
          shift_d = {sr_in, shift_q[WIDTH-1:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
`ifdef PARITY_CHK_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
`ifdef PARITY_CHK_EN
        ST_PARITY: begin
          par_bad_d = ((^shift_q) ^ sr_in) != PARITY_ODD;
          state_d   = ST_STOP;
        end
`endif
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!sr_in) begin
            frame_err_d = 1'b1;
`ifdef PARITY_CHK_EN
          end else if (par_bad_q) begin
            parity_err_d = 1'b1;
`endif
          end else if (!valid_q || out_if.out_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy             = (state_q != ST_IDLE);
    frame_err        = frame_err_q;
`ifdef PARITY_CHK_EN
    parity_err       = parity_err_q;
`else
    parity_err       = 1'b0;
`endif
    overrun          = overrun_q;
    out_if.out_data  = data_q;
    out_if.out_valid = valid_q;
    dbg_state_o      = state_q;
  end

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Directed bench for sipo_rx_ctrl (WIDTH=8, even parity when PARITY_CHK_EN is defined).
module tb_sipo_rx_ctrl;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_en;
  logic       sr_in;
  logic       clr_err;
  logic       busy;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  sipo_rx_ctrl_if #(.WIDTH(W)) out_if ();

  sipo_rx_ctrl #(.WIDTH(W), .PARITY_ODD(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .sr_in      (sr_in),
    .clr_err    (clr_err),
    .out_if     (out_if.master),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    sr_in  = b;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
    repeat (gap) tick();
  endtask

  // Sends start, data LSB first, optional parity, then stop (stop never followed by a gap).
  task automatic send_frame(input logic [W-1:0] d, input logic stop_b, input logic par_b,
                            input int gap, input logic rdy_stop, input logic clr_stop);
    logic saved_rdy;
    send_bit(1'b0, gap);
    if (gap > 0) check("gap_hold_state", 32'(dbg_state), 32'd1);
    for (int i = 0; i < W; i++) send_bit(d[i], gap);
`ifdef PARITY_CHK_EN
    send_bit(par_b, gap);
`else
    if (par_b === 1'bx) $display("note: parity bit unused");
`endif
    saved_rdy = out_if.out_ready;
    if (rdy_stop) out_if.out_ready = 1'b1;
    if (clr_stop) clr_err = 1'b1;
    sr_in  = stop_b;
    bit_en = 1'b1;
    tick();
    bit_en  = 1'b0;
    sr_in   = 1'b1;
    clr_err = 1'b0;
    out_if.out_ready = saved_rdy;
  endtask

  initial begin
    rst = 1'b1; bit_en = 1'b0; sr_in = 1'b1; clr_err = 1'b0;
    out_if.out_ready = 1'b1;
    tick(); tick();
    check("rst_valid", 32'(out_if.out_valid), 32'd0);
    check("rst_data", 32'(out_if.out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flags", {29'd0, frame_err, parity_err, overrun}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    tick();

    // Basic frame 0xA5 with ready high.
    send_frame(8'hA5, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    check("t1_valid", 32'(out_if.out_valid), 32'd1);
    check("t1_data", 32'(out_if.out_data), 32'hA5);
    check("t1_busy", 32'(busy), 32'd0);
    tick();
    check("t1_consumed", 32'(out_if.out_valid), 32'd0);

    // Bad stop bit, then a clean 0x3C frame.
    send_frame(8'hA5, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("t2_frame_err", 32'(frame_err), 32'd1);
    check("t2_no_parity_err", 32'(parity_err), 32'd0);
    check("t2_valid", 32'(out_if.out_valid), 32'd0);
    tick();
    check("t2_pulse_end", 32'(frame_err), 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    check("t2_data", 32'(out_if.out_data), 32'h3C);
    check("t2_valid2", 32'(out_if.out_valid), 32'd1);
    tick();

    // Overrun with ready low, drain, clear.
    out_if.out_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    check("t3_valid", 32'(out_if.out_valid), 32'd1);
    check("t3_ovr0", 32'(overrun), 32'd0);
    send_frame(8'h22, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    check("t3_held", 32'(out_if.out_data), 32'h11);
    check("t3_ovr1", 32'(overrun), 32'd1);
    out_if.out_ready = 1'b1;
    tick();
    check("t3_drained", 32'(out_if.out_valid), 32'd0);
    check("t3_ovr_sticky", 32'(overrun), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t3_ovr_clr", 32'(overrun), 32'd0);

    // New word loads on the same edge the held word is accepted.
    out_if.out_ready = 1'b0;
    send_frame(8'h33, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    send_frame(8'h44, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    check("t3b_valid", 32'(out_if.out_valid), 32'd1);
    check("t3b_data", 32'(out_if.out_data), 32'h44);
    check("t3b_ovr", 32'(overrun), 32'd0);
    tick();
    check("t3b_stable", 32'(out_if.out_data), 32'h44);
    // Overrun set coinciding with clr_err: set wins.
    send_frame(8'h55, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    check("t3c_set_wins", 32'(overrun), 32'd1);
    check("t3c_keep", 32'(out_if.out_data), 32'h44);
    clr_err = 1'b1;
    out_if.out_ready = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t3c_clr", 32'(overrun), 32'd0);
    check("t3c_drain", 32'(out_if.out_valid), 32'd0);

    // Sparse bit_en strobes.
    send_frame(8'hC3, 1'b1, 1'b0, 2, 1'b0, 1'b0);
    check("t4_data", 32'(out_if.out_data), 32'hC3);
    check("t4_valid", 32'(out_if.out_valid), 32'd1);
    tick();

    // Reset mid-frame discards the partial word and the held word.
    out_if.out_ready = 1'b0;
    send_frame(8'h77, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    check("t5_busy_mid", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_valid", 32'(out_if.out_valid), 32'd0);
    check("t5_data", 32'(out_if.out_data), 32'd0);
    out_if.out_ready = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    check("t5_new", 32'(out_if.out_data), 32'h5A);
    tick();

    // Parity: good (even) then bad.
    send_frame(8'hA5, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    check("t6_good_valid", 32'(out_if.out_valid), 32'd1);
    check("t6_good_perr", 32'(parity_err), 32'd0);
    tick();
`ifdef PARITY_CHK_EN
    send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    check("t6_perr", 32'(parity_err), 32'd1);
    check("t6_no_ferr", 32'(frame_err), 32'd0);
    check("t6_valid", 32'(out_if.out_valid), 32'd0);
    tick();
    check("t6_pulse_end", 32'(parity_err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
